ec_point_add_seq: RTL

Parametrised sequential affine point adder over GF(p) for short-Weierstrass curves y² = x³ + a·x + b. It generalises the fixed 256-bit, start-on-reset point adder in three ways: configurable width, modulus and curve coefficient a; valid/ready handshakes on both sides so it can be chained in the MSM bucket pipeline; and full handling of doubling, inverse points and the point at infinity. One operation is in flight at a time.

---
 rtl/ec_point_add_seq_if.sv | 26 ++
 rtl/ec_point_add_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_add_seq_if.sv
// Operand/result handshake bundle for ec_point_add_seq.
// The master side presents operands and accepts results; the slave side is the adder.
interface ec_point_add_seq_if #(
  parameter int WIDTH = 256
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] P;
  logic               P_inf;
  logic [2*WIDTH-1:0] Q;
  logic               Q_inf;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] R;
  logic               R_inf;

  modport master (
    output in_valid, P, P_inf, Q, Q_inf, out_ready,
    input  in_ready, out_valid, R, R_inf
  );

  modport slave (
    input  in_valid, P, P_inf, Q, Q_inf, out_ready,
    output in_ready, out_valid, R, R_inf
  );
endinterface

// File: rtl/ec_point_add_seq.sv
// Sequential affine point adder over GF(P_MOD) for y^2 = x^3 + a*x + b, covering add, doubling,
// inverse points and infinity, built around one shift-add multiplier and a binary Euclid inverter.
module ec_point_add_seq #(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] P_MOD   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [WIDTH-1:0] CURVE_A = '0
) (
  input  logic              clk,
  input  logic              Reset_n,
  ec_point_add_seq_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0]   P_EXT = {1'b0, P_MOD};
  localparam logic [WIDTH+1:0] P_MUL = {2'b00, P_MOD};

  typedef enum logic [3:0] {
    IDLE,
    CLASSIFY,
    SPECIAL,
    NUM_DEN,
    INV,
    MUL_L,
    SQ_L,
    X3,
    Y3,
    DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   px, py, qx, qy;
  logic               p_inf, q_inf;
  logic               is_dbl, res_inf;
  logic [WIDTH-1:0]   num, lam, sq, rx, ry;
  logic [WIDTH-1:0]   u, v, x1, x2;

  logic               in_ready_q, out_valid_q, r_inf_q;
  logic [2*WIDTH-1:0] r_q;

  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [WIDTH+1:0]   mul_acc, mul_step;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_busy, mul_done, mul_start;
  logic [WIDTH-1:0]   mul_op_a, mul_op_b, mul_res;

  logic               x_eq, y_eq, special, u_one, v_one;
  logic [WIDTH-1:0]   sq3, num_calc, den_calc, rx_calc, ry_calc;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P_EXT) s = s - P_EXT;
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    if (a < b) d = d + P_MOD;
    return d;
  endfunction

  // Halving mod an odd prime: odd values borrow one modulus first so the shift is exact.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + P_EXT) : {1'b0, x};
    s = s >> 1;
    return WIDTH'(s);
  endfunction

  assign x_eq    = (px == qx);
  assign y_eq    = (py == qy);
  assign special = p_inf | q_inf | (x_eq & ~y_eq) | (x_eq & y_eq & (py == '0));
  assign u_one   = (u == WIDTH'(1));
  assign v_one   = (v == WIDTH'(1));
  assign mul_res = WIDTH'(mul_acc);

  always_comb begin
    sq3      = mod_add(mod_add(mul_res, mul_res), mul_res);
    num_calc = mod_sub(qy, py);
    den_calc = mod_sub(qx, px);
    if (is_dbl) begin
      num_calc = mod_add(sq3, CURVE_A);
      den_calc = mod_add(py, py);
    end
    rx_calc  = mod_sub(mod_sub(sq, px), qx);
    ry_calc  = mod_sub(mul_res, py);
  end

  // One MSB-first step: double, add a if the current bit of b is set, then fold back below P_MOD.
  always_comb begin
    mul_step = (mul_acc << 1) + (mul_b[WIDTH-1] ? {2'b00, mul_a} : '0);
    if (mul_step >= P_MUL) mul_step = mul_step - P_MUL;
    if (mul_step >= P_MUL) mul_step = mul_step - P_MUL;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_cnt  <= '0;
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        mul_a    <= mul_op_a;
        mul_b    <= mul_op_b;
        mul_acc  <= '0;
        mul_cnt  <= CNT_W'(WIDTH);
        mul_busy <= 1'b1;
      end else if (mul_busy) begin
        mul_acc <= mul_step;
        mul_b   <= mul_b << 1;
        mul_cnt <= mul_cnt - 1'b1;
        if (mul_cnt == CNT_W'(1)) begin
          mul_busy <= 1'b0;
          mul_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Each multiply is launched on the transition into the state that consumes its product.
  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    mul_op_a   = '0;
    mul_op_b   = '0;
    case (state)
      IDLE:     if (bus.in_valid) next_state = CLASSIFY;
      CLASSIFY: begin
        if (special) begin
          next_state = SPECIAL;
        end else begin
          next_state = NUM_DEN;
          if (x_eq) begin
            mul_start = 1'b1;
            mul_op_a  = px;
            mul_op_b  = px;
          end
        end
      end
      SPECIAL:  next_state = DONE;
      NUM_DEN:  if (!is_dbl || mul_done) next_state = INV;
      INV: begin
        if (u_one || v_one) begin
          next_state = MUL_L;
          mul_start  = 1'b1;
          mul_op_a   = num;
          mul_op_b   = u_one ? x1 : x2;
        end
      end
      MUL_L: begin
        if (mul_done) begin
          next_state = SQ_L;
          mul_start  = 1'b1;
          mul_op_a   = mul_res;
          mul_op_b   = mul_res;
        end
      end
      SQ_L:     if (mul_done) next_state = X3;
      X3: begin
        next_state = Y3;
        mul_start  = 1'b1;
        mul_op_a   = lam;
        mul_op_b   = mod_sub(px, rx_calc);
      end
      Y3:       if (mul_done) next_state = DONE;
      DONE:     if (bus.out_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Inverter invariant: x1*den == u and x2*den == v (mod P_MOD); every step halves u or v.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px      <= '0;
      py      <= '0;
      qx      <= '0;
      qy      <= '0;
      p_inf   <= 1'b0;
      q_inf   <= 1'b0;
      is_dbl  <= 1'b0;
      res_inf <= 1'b0;
      num     <= '0;
      lam     <= '0;
      sq      <= '0;
      rx      <= '0;
      ry      <= '0;
      u       <= '0;
      v       <= '0;
      x1      <= '0;
      x2      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            px    <= bus.P[2*WIDTH-1:WIDTH];
            py    <= bus.P[WIDTH-1:0];
            qx    <= bus.Q[2*WIDTH-1:WIDTH];
            qy    <= bus.Q[WIDTH-1:0];
            p_inf <= bus.P_inf;
            q_inf <= bus.Q_inf;
          end
        end
        CLASSIFY: begin
          is_dbl  <= x_eq & y_eq;
          res_inf <= p_inf ? q_inf : (q_inf ? 1'b0 : special);
          rx      <= '0;
          ry      <= '0;
          if (p_inf && !q_inf) begin
            rx <= qx;
            ry <= qy;
          end else if (!p_inf && q_inf) begin
            rx <= px;
            ry <= py;
          end
        end
        NUM_DEN: begin
          if (!is_dbl || mul_done) begin
            num <= num_calc;
            u   <= den_calc;
            v   <= P_MOD;
            x1  <= WIDTH'(1);
            x2  <= '0;
          end
        end
        INV: begin
          if (!(u_one || v_one)) begin
            if (!u[0]) begin
              u  <= u >> 1;
              x1 <= mod_half(x1);
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= mod_half(x2);
            end else if (u >= v) begin
              u  <= (u - v) >> 1;
              x1 <= mod_half(mod_sub(x1, x2));
            end else begin
              v  <= (v - u) >> 1;
              x2 <= mod_half(mod_sub(x2, x1));
            end
          end
        end
        MUL_L:   if (mul_done) lam <= mul_res;
        SQ_L:    if (mul_done) sq <= mul_res;
        X3:      rx <= rx_calc;
        default: ;
      endcase
    end
  end

  // Handshake flags follow the next state so they are registered yet line up with the FSM.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      r_inf_q     <= 1'b0;
    end else begin
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
      if (state == SPECIAL) begin
        r_q     <= {rx, ry};
        r_inf_q <= res_inf;
      end else if (state == Y3 && mul_done) begin
        r_q     <= {rx, ry_calc};
        r_inf_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.R_inf     = r_inf_q;

endmodule
